pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline control unit for the five-stage processor.
- Merges operand forwarding selection, load-use stall detection and branch flush sequencing into one block.
- Adds an interrupt sequencer FSM: drain pipeline, push return PC in two halves, push flags, redirect to the vector.
- Sits beside the F/D and D/E buffers; drives their enables and flushes, plus the Execute-stage forwarding muxes.

Parameters:
- N, 3, register-address width.
- DRAIN_CYCLES, 3, bubbles inserted before an interrupt push sequence (≥1).
- FWD_DEPTH, 2, number of later stages forwarded from (1 = EX/MEM only, 2 = EX/MEM and MEM/WB).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- interrupt  in  1  level request; latched on rising edge.
- id_src, id_dst  in  N  Decode operand addresses.
- id_uses_src, id_uses_dst  in  1  Decode instruction reads that operand.
- ex_src, ex_dst  in  N  Execute-stage operand addresses (D/E outputs).
- ex_mem_read  in  1  Execute instruction is a load.
- mem_dst, wb_dst  in  N  destination in EX/MEM and MEM/WB.
- mem_reg_write, wb_reg_write  in  1  write-enable in EX/MEM and MEM/WB.
- branch_taken  in  1  resolved taken branch/jump in Execute.
- fu_src_sel, fu_dst_sel  out  2  00 register file, 01 EX/MEM ALU_out, 10 MEM/WB WD.
- pc_enb, f_d_enb  out  1  PC and F/D buffer enables.
- f_d_flush, d_e_flush  out  1  bubble insert into the buffer.
- int_push  out  1  inject stack push this cycle.
- int_push_sel  out  2  00 PC high, 01 PC low, 10 flags.
- int_vec_load  out  1  load PC from interrupt vector.
- int_busy  out  1  FSM not IDLE.

Behaviour:
- Reset (async, any time, including mid-sequence):
  - FSM goes to IDLE and the pending latch clears.
  - fu_* = 00; pc_enb = f_d_enb = 1; all other outputs 0.
- Forwarding (combinational):
  - Per operand, EX/MEM match (mem_reg_write && mem_dst == ex_x) takes priority → 01.
  - Otherwise MEM/WB match → 10; otherwise 00.
  - FWD_DEPTH = 1 never produces 10.
- Load-use:
  - Condition: ex_mem_read && ((id_uses_src && id_src == ex_dst) || (id_uses_dst && id_dst == ex_dst)).
  - Response: pc_enb = f_d_enb = 0 and d_e_flush = 1 for exactly one cycle.
- Branch:
  - branch_taken → f_d_flush = d_e_flush = 1 in the same cycle.
  - Branch overrides load-use: pc_enb = 1 so the target loads.
- Priority: rst > branch > load-use > interrupt progression.
- Pending latch:
  - Set on the interrupt rising edge, including while stalled or busy.
  - Cleared on VECTOR entry.
  - A second edge while busy is held, not lost.
- FSM:
  - IDLE: pending && !load-use → DRAIN with cnt = DRAIN_CYCLES−1.
  - DRAIN: pc_enb = f_d_enb = 0, d_e_flush = 1. cnt decrements; cnt == 0 → PUSH_H. branch_taken in DRAIN reloads cnt and lets the PC take the target (PC is the return address).
  - PUSH_H: int_push = 1, sel 00 → PUSH_L.
  - PUSH_L: int_push = 1, sel 01 → PUSH_F.
  - PUSH_F: int_push = 1, sel 10 → VECTOR.
  - VECTOR: int_vec_load = 1, pc_enb = 1, f_d_flush = 1 → IDLE.
  - All states except IDLE hold pc_enb = f_d_enb = 0 (VECTOR excepted) and d_e_flush = 1.
- Latency: interrupt edge to int_vec_load = DRAIN_CYCLES + 4 cycles when unobstructed.
- int_busy = (state != IDLE).

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined: adds output ports stall_cnt[15:0] and flush_cnt[15:0].
  - stall_cnt counts load-use stall cycles; flush_cnt counts branch flush events.
  - Both saturate at 16'hFFFF and are cleared by rst.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - FWD_RF/FWD_EXM/FWD_MWB constants.
  - int_state_t enum (IDLE, DRAIN, PUSH_H, PUSH_L, PUSH_F, VECTOR).
  - PUSH_SEL_* constants.
- Sub-module fwd_unit: combinational operand comparator, instantiated once per operand (src, dst).

Test Plan:
- ex_src = 3, mem_dst = 3 & mem_reg_write, wb_dst = 3 & wb_reg_write → fu_src_sel = 01; drop mem_reg_write → 10; FWD_DEPTH = 1 → 00.
- ex_mem_read = 1, ex_dst = 5, id_src = 5, id_uses_src = 1 → one cycle pc_enb = 0, f_d_enb = 0, d_e_flush = 1, then 1/1/0.
- Load-use and branch_taken in the same cycle → pc_enb = 1, f_d_flush = d_e_flush = 1.
- Interrupt pulse, DRAIN_CYCLES = 3 → 3 drain cycles, push sels 00/01/10, int_vec_load at cycle 7, int_busy high for cycles 1–7.
- Second interrupt edge during PUSH_L → after returning to IDLE, a second full sequence runs.
- rst asserted during PUSH_H → immediate IDLE, int_push = 0, pending cleared; with HAZ_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/interrupt control slice:
// forwarding mux selects, interrupt push selects and the sequencer state type.
package pipe_ctrl_pkg;

  // Execute-stage forwarding mux selects
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file operand
  localparam logic [1:0] FWD_EXM = 2'b01;  // EX/MEM ALU_out
  localparam logic [1:0] FWD_MWB = 2'b10;  // MEM/WB write data

  // Interrupt stack push selects
  localparam logic [1:0] PUSH_SEL_PC_H  = 2'b00;
  localparam logic [1:0] PUSH_SEL_PC_L  = 2'b01;
  localparam logic [1:0] PUSH_SEL_FLAGS = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    PUSH_H,
    PUSH_L,
    PUSH_F,
    VECTOR
  } int_state_t;

  // Saturating 16-bit increment used by the optional performance counters
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? (v + 16'd1) : v;
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding comparator for one Execute-stage operand.
// EX/MEM has priority over MEM/WB; with FWD_DEPTH = 1 only EX/MEM is used.
module fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned N         = 3,
  parameter int unsigned FWD_DEPTH = 2
) (
  input  logic [N-1:0] ex_addr,
  input  logic [N-1:0] mem_dst,
  input  logic         mem_reg_write,
  input  logic [N-1:0] wb_dst,
  input  logic         wb_reg_write,
  output logic [1:0]   sel
);

  // Pick the youngest in-flight producer of this operand
  always_comb begin
    sel = FWD_RF;
    if (mem_reg_write && (mem_dst == ex_addr)) begin
      sel = FWD_EXM;
    end else if ((FWD_DEPTH >= 2) && wb_reg_write && (wb_dst == ex_addr)) begin
      sel = FWD_MWB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control unit for the five-stage core: operand forwarding selects,
// load-use stall, taken-branch flush and the interrupt entry sequencer
// (drain, push PC high/low, push flags, vector).
// Optional build macro HAZ_PERF_CNT_EN adds saturating stall/flush counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned N            = 3,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned FWD_DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         interrupt,
  input  logic [N-1:0] id_src,
  input  logic [N-1:0] id_dst,
  input  logic         id_uses_src,
  input  logic         id_uses_dst,
  input  logic [N-1:0] ex_src,
  input  logic [N-1:0] ex_dst,
  input  logic         ex_mem_read,
  input  logic [N-1:0] mem_dst,
  input  logic [N-1:0] wb_dst,
  input  logic         mem_reg_write,
  input  logic         wb_reg_write,
  input  logic         branch_taken,
  output logic [1:0]   fu_src_sel,
  output logic [1:0]   fu_dst_sel,
  output logic         pc_enb,
  output logic         f_d_enb,
  output logic         f_d_flush,
  output logic         d_e_flush,
  output logic         int_push,
  output logic [1:0]   int_push_sel,
  output logic         int_vec_load,
  output logic         int_busy
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0]  stall_cnt,
  output logic [15:0]  flush_cnt
`endif
);

  localparam int unsigned CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(DRAIN_CYCLES - 1);

  int_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          int_q;
  // pending_q: request being (or about to be) serviced; held_q: one more
  // request that arrived while the sequencer was already busy.
  logic          pending_q, pending_d;
  logic          held_q, held_d;
  logic          load_use;
  logic          int_edge;
  logic          vec_entry;
  logic [1:0]    src_sel, dst_sel;

  assign load_use = ex_mem_read &&
                    ((id_uses_src && (id_src == ex_dst)) ||
                     (id_uses_dst && (id_dst == ex_dst)));
  assign int_edge  = interrupt && !int_q;
  assign vec_entry = (state_q == PUSH_F);

  fwd_unit #(
    .N        (N),
    .FWD_DEPTH(FWD_DEPTH)
  ) u_fwd_src (
    .ex_addr      (ex_src),
    .mem_dst      (mem_dst),
    .mem_reg_write(mem_reg_write),
    .wb_dst       (wb_dst),
    .wb_reg_write (wb_reg_write),
    .sel          (src_sel)
  );

  fwd_unit #(
    .N        (N),
    .FWD_DEPTH(FWD_DEPTH)
  ) u_fwd_dst (
    .ex_addr      (ex_dst),
    .mem_dst      (mem_dst),
    .mem_reg_write(mem_reg_write),
    .wb_dst       (wb_dst),
    .wb_reg_write (wb_reg_write),
    .sel          (dst_sel)
  );

  // Sequencer next state and drain countdown
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if ((pending_q || held_q || int_edge) && !load_use) begin
          state_d = DRAIN;
          cnt_d   = CNT_RELOAD;
        end
      end
      DRAIN: begin
        // A taken branch restarts the drain so the PC settles on the target,
        // which becomes the return address.
        if (branch_taken) begin
          cnt_d = CNT_RELOAD;
        end else if (cnt_q == '0) begin
          state_d = PUSH_H;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      PUSH_H:  state_d = PUSH_L;
      PUSH_L:  state_d = PUSH_F;
      PUSH_F:  state_d = VECTOR;
      VECTOR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latching: edges while busy are held and promoted at vector entry
  always_comb begin
    pending_d = pending_q;
    held_d    = held_q;
    if (state_q == IDLE) begin
      pending_d = pending_q || held_q || int_edge;
      held_d    = 1'b0;
    end else if (vec_entry) begin
      pending_d = held_q || int_edge;
      held_d    = 1'b0;
    end else begin
      held_d = held_q || int_edge;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      int_q     <= 1'b0;
      pending_q <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      int_q     <= interrupt;
      pending_q <= pending_d;
      held_q    <= held_d;
    end
  end

  // Output decode: sequencer first, then load-use, then branch on top
  always_comb begin
    fu_src_sel   = FWD_RF;
    fu_dst_sel   = FWD_RF;
    pc_enb       = 1'b1;
    f_d_enb      = 1'b1;
    f_d_flush    = 1'b0;
    d_e_flush    = 1'b0;
    int_push     = 1'b0;
    int_push_sel = PUSH_SEL_PC_H;
    int_vec_load = 1'b0;
    int_busy     = 1'b0;
    if (!rst) begin
      fu_src_sel = src_sel;
      fu_dst_sel = dst_sel;
      int_busy   = (state_q != IDLE);
      case (state_q)
        DRAIN: begin
          pc_enb    = 1'b0;
          f_d_enb   = 1'b0;
          d_e_flush = 1'b1;
        end
        PUSH_H, PUSH_L, PUSH_F: begin
          pc_enb    = 1'b0;
          f_d_enb   = 1'b0;
          d_e_flush = 1'b1;
          int_push  = 1'b1;
          if (state_q == PUSH_L) begin
            int_push_sel = PUSH_SEL_PC_L;
          end else if (state_q == PUSH_F) begin
            int_push_sel = PUSH_SEL_FLAGS;
          end
        end
        VECTOR: begin
          int_vec_load = 1'b1;
          f_d_flush    = 1'b1;
          d_e_flush    = 1'b1;
        end
        default: ;
      endcase
      if (load_use) begin
        pc_enb    = 1'b0;
        f_d_enb   = 1'b0;
        d_e_flush = 1'b1;
      end
      if (branch_taken) begin
        pc_enb    = 1'b1;
        f_d_enb   = 1'b1;
        f_d_flush = 1'b1;
        d_e_flush = 1'b1;
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_q, flush_q;

  // Stall cycles exclude those overridden by a taken branch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= sat_inc(stall_q, load_use && !branch_taken);
      flush_q <= sat_inc(flush_q, branch_taken);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`endif

endmodule
